simplespi_target: RTL and testbench

SPI target (slave) endpoint, the far end of the SoC's `simplespi` master link. It receives bytes shifted in by an external SPI master on MOSI and returns CPU-supplied bytes on MISO, using mode 0, MSB first, 8-bit frames. It sits on the PicoSoC register bus beside the UART and SPI master. All SPI pins are oversampled into the `clk` domain, so no SCK clock domain exists.

---
 rtl/simplespi_pkg.sv | 27 ++
 rtl/simplespi_target_if.sv | 27 ++
 rtl/spi_sync_edge.sv | 42 ++++
 rtl/simplespi_target.sv | 210 +++++++++++++++++++++
 tb/tb_simplespi_target.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simplespi_pkg.sv
// simplespi_pkg
//   Shared definitions for the simplespi_target SPI endpoint. It holds the
//   state encoding, the bit positions in the status/control register, the
//   byte driven on MISO when no TX data is queued, and the idle levels that
//   the pin synchronizers reset to.
package simplespi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int CONF_RX_VALID = 0;
    localparam int CONF_TX_FULL  = 1;
    localparam int CONF_OVERRUN  = 2;
    localparam int CONF_UNDERRUN = 3;
    localparam int CONF_ACTIVE   = 4;
    localparam int CONF_IRQ_EN   = 5;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Pin levels of an idle, deselected bus
    localparam logic SCK_RST  = 1'b0;
    localparam logic CS_N_RST = 1'b1;
    localparam logic MOSI_RST = 1'b1;

endpackage

// File: rtl/simplespi_target_if.sv
// simplespi_target_if
//   PicoSoC register-bus connection of simplespi_target.
//   reg_conf_we/di/do : status/control register (byte enables, write data, read value)
//   reg_dat_we/di     : TX byte write strobe and data ([7:0] used)
//   reg_dat_re/do     : RX byte pop strobe and read data
//   The master modport is the CPU side, the slave modport the endpoint.
interface simplespi_target_if;

    logic [3:0]  reg_conf_we;
    logic [31:0] reg_conf_di;
    logic [31:0] reg_conf_do;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;

    modport master (
        output reg_conf_we, reg_conf_di, reg_dat_we, reg_dat_re, reg_dat_di,
        input  reg_conf_do, reg_dat_do
    );

    modport slave (
        input  reg_conf_we, reg_conf_di, reg_dat_we, reg_dat_re, reg_dat_di,
        output reg_conf_do, reg_dat_do
    );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
//   flops, followed by one history flop used for edge detection.
//   Parameters: SYNC_STAGES (>= 2), RST_VAL (idle level of the pin)
//   clk, resetn : system clock, synchronous active-low reset
//   din         : raw pin
//   level       : synchronized level (last synchronizer flop)
//   rise, fall  : one-cycle pulses from the last synchronizer flop vs history
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("spi_sync_edge: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            hist  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = chain[SYNC_STAGES-1] & ~hist;
    assign fall  = ~chain[SYNC_STAGES-1] & hist;

endmodule

// File: rtl/simplespi_target.sv
// simplespi_target
//   SPI target endpoint (mode 0, MSB first, 8-bit frames). All SPI pins are
//   oversampled in clk, so there is no SCK clock domain. Received bytes are
//   held in a one-deep RX buffer; one queued TX byte is sent per frame byte,
//   with 8'hFF (and the underrun flag) when none is queued.
//   Build option: SIMPLESPI_TARGET_IRQ_EN adds the irq port and the irq_en bit.
//   clk, resetn          : system clock, synchronous active-low reset
//   spi_sck/cs_n/mosi    : asynchronous SPI pins from the master
//   spi_miso, spi_miso_oe: MISO data and its output enable (high while selected)
//   bus                  : register bus (status/control and data registers)
//   irq                  : level interrupt (only with SIMPLESPI_TARGET_IRQ_EN)
module simplespi_target
    import simplespi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
`ifdef SIMPLESPI_TARGET_IRQ_EN
    output logic irq,
`endif
    simplespi_target_if.slave bus
);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCK_RST)) u_sync_sck (
        .clk(clk), .resetn(resetn), .din(spi_sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CS_N_RST)) u_sync_cs (
        .clk(clk), .resetn(resetn), .din(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(MOSI_RST)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .din(spi_mosi),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_t state_q, state_d;

    logic [2:0] bitcnt;
    logic [7:0] rx_shift, rx_buf, tx_shift, tx_buf;
    logic       rx_valid, tx_full, overrun, underrun, irq_en;

    logic enter, leave, shift_in, shift_out, load_next, load;
    logic byte_done, conf_wr;
    logic [7:0] byte_val;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Deselect takes priority over any SCK edge seen in the same cycle.
    always_comb begin
        enter     = 1'b0;
        leave     = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        load_next = 1'b0;
        case (state_q)
            ST_IDLE: enter = cs_fall;
            ST_ACTIVE: begin
                if (cs_rise) begin
                    leave = 1'b1;
                end else begin
                    shift_in = sck_rise;
                    if (sck_fall) begin
                        if (bitcnt == 3'd0) load_next = 1'b1;
                        else                shift_out = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign load      = enter | load_next;
    assign byte_val  = {rx_shift[6:0], mosi_s};
    assign byte_done = shift_in & (bitcnt == 3'd7);
    assign conf_wr   = bus.reg_conf_we[0];

    // ---------------- SPI shift path ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bitcnt      <= 3'd0;
            rx_shift    <= 8'd0;
            spi_miso_oe <= 1'b0;
        end else if (enter) begin
            bitcnt      <= 3'd0;
            spi_miso_oe <= 1'b1;
        end else if (leave) begin
            bitcnt      <= 3'd0;
            rx_shift    <= 8'd0;
            spi_miso_oe <= 1'b0;
        end else if (shift_in) begin
            bitcnt      <= bitcnt + 3'd1;
            rx_shift    <= byte_val;
        end
    end

    // Bits shifted out are back-filled with 1 so an idle MISO reads high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_shift <= FILL_BYTE;
        end else if (load) begin
            tx_shift <= tx_full ? tx_buf : FILL_BYTE;
        end else if (leave) begin
            tx_shift <= FILL_BYTE;
        end else if (shift_out) begin
            tx_shift <= {tx_shift[6:0], 1'b1};
        end
    end

    assign spi_miso = tx_shift[7];

    // ---------------- TX buffer ----------------
    // A load only consumes a full buffer and a write only fills an empty one,
    // so the two never fight over tx_full.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_buf  <= 8'd0;
            tx_full <= 1'b0;
        end else if (load && tx_full) begin
            tx_full <= 1'b0;
        end else if (bus.reg_dat_we && !tx_full) begin
            tx_buf  <= bus.reg_dat_di[7:0];
            tx_full <= 1'b1;
        end
    end

    // ---------------- RX buffer ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_buf   <= 8'd0;
            rx_valid <= 1'b0;
        end else if (byte_done) begin
            rx_buf   <= byte_val;
            rx_valid <= 1'b1;
        end else if (bus.reg_dat_re) begin
            rx_valid <= 1'b0;
        end
    end

    // ---------------- sticky flags (set wins over W1C) ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= (byte_done & rx_valid & ~bus.reg_dat_re) |
                        (overrun & ~(conf_wr & bus.reg_conf_di[CONF_OVERRUN]));
            underrun <= (load & ~tx_full) |
                        (underrun & ~(conf_wr & bus.reg_conf_di[CONF_UNDERRUN]));
        end
    end

`ifdef SIMPLESPI_TARGET_IRQ_EN
    always_ff @(posedge clk) begin
        if (!resetn)      irq_en <= 1'b0;
        else if (conf_wr) irq_en <= bus.reg_conf_di[CONF_IRQ_EN];
    end

    always_ff @(posedge clk) begin
        if (!resetn) irq <= 1'b0;
        else         irq <= irq_en & (rx_valid | overrun | underrun);
    end
`else
    assign irq_en = 1'b0;
`endif

    // ---------------- register read path ----------------
    always_comb begin
        bus.reg_conf_do                = 32'd0;
        bus.reg_conf_do[CONF_RX_VALID] = rx_valid;
        bus.reg_conf_do[CONF_TX_FULL]  = tx_full;
        bus.reg_conf_do[CONF_OVERRUN]  = overrun;
        bus.reg_conf_do[CONF_UNDERRUN] = underrun;
        bus.reg_conf_do[CONF_ACTIVE]   = (state_q == ST_ACTIVE);
        bus.reg_conf_do[CONF_IRQ_EN]   = irq_en;
    end

    assign bus.reg_dat_do = rx_valid ? {24'd0, rx_buf} : 32'hFFFF_FFFF;

    // Pins and bus bits this block does not look at
    logic unused_ok;
    assign unused_ok = ^{sck_level, cs_level, mosi_rise, mosi_fall,
                         bus.reg_conf_we, bus.reg_conf_di, bus.reg_dat_di};

endmodule

// File: tb/tb_simplespi_target.sv
// tb_simplespi_target
//   Directed bench for simplespi_target: a bit-banged mode-0 SPI master with
//   a half period of 6 clk, register-bus helpers, and hand-computed
//   expectations for each scenario. Build with SIMPLESPI_TARGET_IRQ_EN
//   defined to also cover the interrupt.
module tb_simplespi_target;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic resetn;
    logic spi_sck, spi_cs_n, spi_mosi;
    logic spi_miso, spi_miso_oe;
`ifdef SIMPLESPI_TARGET_IRQ_EN
    logic irq;
`endif

    simplespi_target_if bus ();

    simplespi_target #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
`ifdef SIMPLESPI_TARGET_IRQ_EN
        .irq         (irq),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mosi_q [0:1];
    logic [7:0] miso_rx [0:1];
    logic       oe_seen;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic conf_wr(input logic [31:0] d);
        @(negedge clk);
        bus.reg_conf_we = 4'h1;
        bus.reg_conf_di = d;
        @(negedge clk);
        bus.reg_conf_we = 4'h0;
        bus.reg_conf_di = 32'd0;
    endtask

    task automatic tx_wr(input logic [7:0] d);
        @(negedge clk);
        bus.reg_dat_we = 1'b1;
        bus.reg_dat_di = {24'd0, d};
        @(negedge clk);
        bus.reg_dat_we = 1'b0;
        bus.reg_dat_di = 32'd0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.reg_dat_re = 1'b1;
        @(negedge clk);
        bus.reg_dat_re = 1'b0;
    endtask

    // Mode-0 frame of nbits bits from mosi_q; MISO captured just before each
    // rise. The last fall is issued together with deselect. With pop_last,
    // the pop strobe lands in the cycle the final byte completes.
    task automatic spi_frame(input int nbits, input bit pop_last);
        int byte_i, bit_i;
        spi_cs_n = 1'b0;
        spi_mosi = mosi_q[0][7];
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            byte_i = b / 8;
            bit_i  = 7 - (b % 8);
            if (b != 0) begin
                spi_mosi = mosi_q[byte_i][bit_i];
                repeat (HALF) @(negedge clk);
            end
            miso_rx[byte_i][bit_i] = spi_miso;
            if (b == 0) oe_seen = spi_miso_oe;
            spi_sck = 1'b1;
            for (int i = 1; i <= HALF; i++) begin
                @(negedge clk);
                bus.reg_dat_re = pop_last && (b == nbits - 1) && (i == 2);
            end
            if (b != nbits - 1) spi_sck = 1'b0;
        end
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        resetn          = 1'b0;
        spi_sck         = 1'b0;
        spi_cs_n        = 1'b1;
        spi_mosi        = 1'b1;
        bus.reg_conf_we = 4'h0;
        bus.reg_conf_di = 32'd0;
        bus.reg_dat_we  = 1'b0;
        bus.reg_dat_re  = 1'b0;
        bus.reg_dat_di  = 32'd0;
        mosi_q[0] = 8'h00;
        mosi_q[1] = 8'h00;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_conf", bus.reg_conf_do, 32'h0);
        chk("rst_dat",  bus.reg_dat_do,  32'hFFFF_FFFF);
        chk("rst_miso", 32'(spi_miso), 32'h1);
        chk("rst_oe",   32'(spi_miso_oe), 32'h0);
`ifdef SIMPLESPI_TARGET_IRQ_EN
        chk("rst_irq",  32'(irq), 32'h0);
`endif

        // Basic RX with preloaded TX
        tx_wr(8'hA5);
        chk("basic_txfull", bus.reg_conf_do, 32'h2);
        mosi_q[0] = 8'h3C;
        spi_frame(8, 1'b0);
        chk("basic_oe_active", 32'(oe_seen), 32'h1);
        chk("basic_dat",  bus.reg_dat_do, 32'h3C);
        chk("basic_miso", 32'(miso_rx[0]), 32'hA5);
        chk("basic_conf", bus.reg_conf_do, 32'h1);
        chk("basic_oe_idle", 32'(spi_miso_oe), 32'h0);
        pop();
        chk("basic_popped", bus.reg_dat_do, 32'hFFFF_FFFF);

        // Underrun: two-byte frame, one byte queued
        tx_wr(8'h11);
        mosi_q[0] = 8'h55;
        mosi_q[1] = 8'hAA;
        spi_frame(16, 1'b0);
        chk("under_miso0", 32'(miso_rx[0]), 32'h11);
        chk("under_miso1", 32'(miso_rx[1]), 32'hFF);
        chk("under_bit3", 32'(bus.reg_conf_do[3]), 32'h1);
        chk("under_conf", bus.reg_conf_do, 32'hD);
        chk("under_dat",  bus.reg_dat_do, 32'hAA);
        conf_wr(32'h8);
        chk("under_w1c", bus.reg_conf_do, 32'h5);
        conf_wr(32'h4);
        pop();
        chk("under_clean", bus.reg_conf_do, 32'h0);

        // Overrun: two frames without popping
        mosi_q[0] = 8'h01;
        spi_frame(8, 1'b0);
        mosi_q[0] = 8'h02;
        spi_frame(8, 1'b0);
        chk("over_bit2", 32'(bus.reg_conf_do[2]), 32'h1);
        chk("over_conf", bus.reg_conf_do, 32'hD);
        chk("over_dat",  bus.reg_dat_do, 32'h02);
        pop();
        chk("over_after_pop", bus.reg_dat_do, 32'hFFFF_FFFF);
        conf_wr(32'hC);
        chk("over_clean", bus.reg_conf_do, 32'h0);

        // Abort after 5 SCK rises, then a complete frame
        mosi_q[0] = 8'hF0;
        spi_frame(5, 1'b0);
        chk("abort_oe_active", 32'(oe_seen), 32'h1);
        chk("abort_oe_idle", 32'(spi_miso_oe), 32'h0);
        chk("abort_conf", bus.reg_conf_do, 32'h8);
        mosi_q[0] = 8'hC3;
        spi_frame(8, 1'b0);
        chk("abort_next_dat", bus.reg_dat_do, 32'hC3);
        chk("abort_next_conf", bus.reg_conf_do, 32'h9);
        conf_wr(32'hC);
        pop();

        // Pop in the same cycle a byte completes while rx_valid is set
        mosi_q[0] = 8'h5A;
        spi_frame(8, 1'b0);
        chk("simul_pre", bus.reg_dat_do, 32'h5A);
        mosi_q[0] = 8'h77;
        spi_frame(8, 1'b1);
        chk("simul_dat",     bus.reg_dat_do, 32'h77);
        chk("simul_valid",   32'(bus.reg_conf_do[0]), 32'h1);
        chk("simul_overrun", 32'(bus.reg_conf_do[2]), 32'h0);
        conf_wr(32'hC);
        pop();

        // TX write while full is dropped
        tx_wr(8'h12);
        tx_wr(8'h34);
        chk("drop_conf", bus.reg_conf_do, 32'h2);
        mosi_q[0] = 8'h00;
        spi_frame(8, 1'b0);
        chk("drop_miso", 32'(miso_rx[0]), 32'h12);
        chk("drop_after", bus.reg_conf_do, 32'h1);
        pop();

        // irq_en bit
        conf_wr(32'h20);
`ifdef SIMPLESPI_TARGET_IRQ_EN
        chk("irqen_read", bus.reg_conf_do, 32'h20);
        chk("irq_idle", 32'(irq), 32'h0);
        tx_wr(8'h5E);
        mosi_q[0] = 8'h96;
        fork
            spi_frame(8, 1'b0);
            begin
                found = 1'b0;
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clk);
                    if (bus.reg_conf_do[0]) found = 1'b1;
                end
                chk("irq_wait_valid", 32'(found), 32'h1);
                chk("irq_same_cycle", 32'(irq), 32'h0);
                @(negedge clk);
                chk("irq_rise", 32'(irq), 32'h1);
            end
        join
        chk("irq_dat", bus.reg_dat_do, 32'h96);
        pop();
        chk("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        chk("irq_fall", 32'(irq), 32'h0);
        conf_wr(32'h0);
        tx_wr(8'h5E);
        mosi_q[0] = 8'h3A;
        spi_frame(8, 1'b0);
        chk("irq_dis_valid", bus.reg_conf_do, 32'h1);
        chk("irq_dis", 32'(irq), 32'h0);
        pop();
`else
        chk("irqen_ignored", bus.reg_conf_do, 32'h0);
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
